// File: rtl/cpu_defs.sv
// Shared CPU pipeline definitions: instruction/register types, decoded
// operation enumeration, decoded-entry record and small helpers used by the
// decode stage and its queue.
package cpu_defs;

    typedef logic [31:0] Inst_t;
    typedef logic [4:0]  RegAddr_t;

    // Branch operations are kept contiguous (OP_BEQ..OP_BGEZAL) so that
    // is_branch() reduces to a range compare.
    typedef enum logic [4:0] {
        OP_INVALID = 5'd0,
        OP_ANDI    = 5'd1,
        OP_ORI     = 5'd2,
        OP_XORI    = 5'd3,
        OP_LUI     = 5'd4,
        OP_ADDIU   = 5'd5,
        OP_SLTI    = 5'd6,
        OP_SLTIU   = 5'd7,
        OP_BEQ     = 5'd8,
        OP_BNE     = 5'd9,
        OP_BLEZ    = 5'd10,
        OP_BGTZ    = 5'd11,
        OP_BLTZ    = 5'd12,
        OP_BGEZ    = 5'd13,
        OP_BLTZAL  = 5'd14,
        OP_BGEZAL  = 5'd15,
        OP_TEQI    = 5'd16,
        OP_LW      = 5'd17,
        OP_LB      = 5'd18,
        OP_LBU     = 5'd19,
        OP_SW      = 5'd20,
        OP_SB      = 5'd21
    } Oper_t;

    // Primary opcode field values (inst[31:26]).
    localparam logic [5:0] OPC_REGIMM = 6'h01;
    localparam logic [5:0] OPC_BEQ    = 6'h04;
    localparam logic [5:0] OPC_BNE    = 6'h05;
    localparam logic [5:0] OPC_BLEZ   = 6'h06;
    localparam logic [5:0] OPC_BGTZ   = 6'h07;
    localparam logic [5:0] OPC_ADDIU  = 6'h09;
    localparam logic [5:0] OPC_SLTI   = 6'h0A;
    localparam logic [5:0] OPC_SLTIU  = 6'h0B;
    localparam logic [5:0] OPC_ANDI   = 6'h0C;
    localparam logic [5:0] OPC_ORI    = 6'h0D;
    localparam logic [5:0] OPC_XORI   = 6'h0E;
    localparam logic [5:0] OPC_LUI    = 6'h0F;
    localparam logic [5:0] OPC_LB     = 6'h20;
    localparam logic [5:0] OPC_LW     = 6'h23;
    localparam logic [5:0] OPC_LBU    = 6'h24;
    localparam logic [5:0] OPC_SB     = 6'h28;
    localparam logic [5:0] OPC_SW     = 6'h2B;

    // REGIMM sub-opcodes carried in the rt field.
    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_TEQI    = 5'h0C;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    // Link register written by the and-link branches.
    localparam RegAddr_t LINK_REG = 5'd31;

    typedef struct packed {
        Oper_t       op;
        RegAddr_t    raddr1;
        RegAddr_t    raddr2;
        RegAddr_t    waddr;
        logic        we;
        logic [31:0] imm;
        logic [31:0] pc;
    } DecodedInst_t;

    // True for every op that owns a delay slot.
    function automatic logic is_branch(input Oper_t op);
        return (op >= OP_BEQ) && (op <= OP_BGEZAL);
    endfunction

endpackage

// File: rtl/id_decode_queue_if.sv
// Fetch-side and issue-side bundle of the decode queue. The fetch unit and
// issue consumer sit on the master side; the queue is the slave.
interface id_decode_queue_if
    import cpu_defs::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2
) ();

    localparam int CW = $clog2(FETCH_WIDTH + 1);
    localparam int IW = $clog2(ISSUE_WIDTH + 1);

    logic                              flush;
    logic                              fetch_valid;
    logic                              fetch_ready;
    logic [CW-1:0]                     fetch_cnt;
    Inst_t    [FETCH_WIDTH-1:0]        fetch_inst;
    logic [31:0]                       fetch_pc;

    logic [IW-1:0]                     issue_count;
    logic                              issue_ready;
    Oper_t    [ISSUE_WIDTH-1:0]        issue_op;
    RegAddr_t [ISSUE_WIDTH-1:0]        issue_raddr1;
    RegAddr_t [ISSUE_WIDTH-1:0]        issue_raddr2;
    RegAddr_t [ISSUE_WIDTH-1:0]        issue_waddr;
    logic     [ISSUE_WIDTH-1:0]        issue_we;
    logic     [ISSUE_WIDTH-1:0][31:0]  issue_imm;
    logic     [ISSUE_WIDTH-1:0][31:0]  issue_pc;
    logic     [ISSUE_WIDTH-1:0]        issue_invalid;

    modport master (
        output flush, fetch_valid, fetch_cnt, fetch_inst, fetch_pc, issue_ready,
        input  fetch_ready, issue_count, issue_op, issue_raddr1, issue_raddr2,
               issue_waddr, issue_we, issue_imm, issue_pc, issue_invalid
    );

    modport slave (
        input  flush, fetch_valid, fetch_cnt, fetch_inst, fetch_pc, issue_ready,
        output fetch_ready, issue_count, issue_op, issue_raddr1, issue_raddr2,
               issue_waddr, issue_we, issue_imm, issue_pc, issue_invalid
    );

endinterface

// File: rtl/id_decode_lane.sv
// Combinational decoder for one I-type instruction: produces the operation,
// register addresses, write enable and extended immediate.
module id_decode_lane
    import cpu_defs::*;
(
    input  Inst_t        i_inst,
    input  logic [31:0]  i_pc,
    output DecodedInst_t o_dec
);

    logic [5:0]  w_opc;
    RegAddr_t    w_rs;
    RegAddr_t    w_rt;
    logic [15:0] w_k;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [31:0] w_bimm;
    logic [31:0] w_lui;

    assign w_opc  = i_inst[31:26];
    assign w_rs   = i_inst[25:21];
    assign w_rt   = i_inst[20:16];
    assign w_k    = i_inst[15:0];
    assign w_sext = {{16{w_k[15]}}, w_k};
    assign w_zext = {16'h0000, w_k};
    assign w_bimm = {w_sext[29:0], 2'b00};
    assign w_lui  = {w_k, 16'h0000};

    // Opcode decode; unknown encodings stay OP_INVALID with no write.
    always_comb begin
        o_dec        = '0;
        o_dec.op     = OP_INVALID;
        o_dec.pc     = i_pc;
        o_dec.imm    = w_sext;
        o_dec.raddr1 = w_rs;
        case (w_opc)
            OPC_ANDI, OPC_ORI, OPC_XORI: begin
                o_dec.op    = (w_opc == OPC_ANDI) ? OP_ANDI :
                              (w_opc == OPC_ORI)  ? OP_ORI  : OP_XORI;
                o_dec.waddr = w_rt;
                o_dec.we    = 1'b1;
                o_dec.imm   = w_zext;
            end
            OPC_ADDIU, OPC_SLTI, OPC_SLTIU: begin
                o_dec.op    = (w_opc == OPC_ADDIU) ? OP_ADDIU :
                              (w_opc == OPC_SLTI)  ? OP_SLTI  : OP_SLTIU;
                o_dec.waddr = w_rt;
                o_dec.we    = 1'b1;
            end
            OPC_LUI: begin
                // LUI has no source operand; read r0 so no hazard is seen.
                o_dec.op     = OP_LUI;
                o_dec.raddr1 = '0;
                o_dec.waddr  = w_rt;
                o_dec.we     = 1'b1;
                o_dec.imm    = w_lui;
            end
            OPC_LW, OPC_LB, OPC_LBU: begin
                o_dec.op     = (w_opc == OPC_LW) ? OP_LW :
                               (w_opc == OPC_LB) ? OP_LB : OP_LBU;
                o_dec.raddr2 = w_rt;
                o_dec.waddr  = w_rt;
                o_dec.we     = 1'b1;
            end
            OPC_SW, OPC_SB: begin
                o_dec.op     = (w_opc == OPC_SW) ? OP_SW : OP_SB;
                o_dec.raddr2 = w_rt;
            end
            OPC_BEQ, OPC_BNE: begin
                o_dec.op     = (w_opc == OPC_BEQ) ? OP_BEQ : OP_BNE;
                o_dec.raddr2 = w_rt;
                o_dec.imm    = w_bimm;
            end
            OPC_BLEZ, OPC_BGTZ: begin
                o_dec.op  = (w_opc == OPC_BLEZ) ? OP_BLEZ : OP_BGTZ;
                o_dec.imm = w_bimm;
            end
            OPC_REGIMM: begin
                case (w_rt)
                    RT_BLTZ: begin
                        o_dec.op  = OP_BLTZ;
                        o_dec.imm = w_bimm;
                    end
                    RT_BGEZ: begin
                        o_dec.op  = OP_BGEZ;
                        o_dec.imm = w_bimm;
                    end
                    RT_BLTZAL, RT_BGEZAL: begin
                        o_dec.op    = (w_rt == RT_BLTZAL) ? OP_BLTZAL : OP_BGEZAL;
                        o_dec.waddr = LINK_REG;
                        o_dec.we    = 1'b1;
                        o_dec.imm   = w_bimm;
                    end
                    RT_TEQI: begin
                        o_dec.op = OP_TEQI;
                    end
                    default: begin
                        o_dec.op = OP_INVALID;
                    end
                endcase
            end
            default: begin
                o_dec.op = OP_INVALID;
            end
        endcase
    end

endmodule

// File: rtl/id_decode_queue.sv
// Multi-lane decode-and-buffer stage between fetch and issue. Instructions
// are decoded on entry, held in an in-order circular queue and presented to
// issue in groups that never split a branch from its delay slot.
module id_decode_queue
    import cpu_defs::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8
) (
    input  logic              clk,
    input  logic              rst,
    id_decode_queue_if.slave  bus
);

    localparam int CW = $clog2(FETCH_WIDTH + 1);
    localparam int IW = $clog2(ISSUE_WIDTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    DecodedInst_t  r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [NW-1:0] r_count;

    DecodedInst_t  w_dec [FETCH_WIDTH];
    DecodedInst_t  w_rd  [ISSUE_WIDTH];
    logic          w_ready;
    logic          w_push;
    logic [CW-1:0] w_push_cnt;
    logic [IW-1:0] w_avail;
    logic          w_tail_branch;
    logic [IW-1:0] w_issue_cnt;
    logic [IW-1:0] w_pop_cnt;

    // One decoder per fetch lane; lane i sits at fetch_pc + 4*i.
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
        id_decode_lane u_lane (
            .i_inst (bus.fetch_inst[gi]),
            .i_pc   (bus.fetch_pc + 32'(4 * gi)),
            .o_dec  (w_dec[gi])
        );
    end

    // Head-relative read ports; the pointer sum wraps naturally at DEPTH.
    for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_rd
        assign w_rd[gi]              = r_mem[r_head + PW'(gi)];
        assign bus.issue_op[gi]      = w_rd[gi].op;
        assign bus.issue_raddr1[gi]  = w_rd[gi].raddr1;
        assign bus.issue_raddr2[gi]  = w_rd[gi].raddr2;
        assign bus.issue_waddr[gi]   = w_rd[gi].waddr;
        assign bus.issue_we[gi]      = w_rd[gi].we;
        assign bus.issue_imm[gi]     = w_rd[gi].imm;
        assign bus.issue_pc[gi]      = w_rd[gi].pc;
        assign bus.issue_invalid[gi] = (w_rd[gi].op == OP_INVALID);
    end

    // Space check uses only the registered count, so a beat is accepted
    // regardless of what issue pops in the same cycle.
    assign w_ready         = (r_count <= NW'(DEPTH - FETCH_WIDTH));
    assign bus.fetch_ready = w_ready;
    assign w_push          = bus.fetch_valid && w_ready && !bus.flush;
    assign w_push_cnt      = w_push ? bus.fetch_cnt : '0;

    // Issue group size: hold back a trailing branch until its slot is queued.
    always_comb begin
        w_avail       = (r_count >= NW'(ISSUE_WIDTH)) ? IW'(ISSUE_WIDTH) : IW'(r_count);
        w_tail_branch = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if ((w_avail == IW'(i + 1)) && is_branch(w_rd[i].op)) begin
                w_tail_branch = 1'b1;
            end
        end
        if (bus.flush) begin
            w_issue_cnt = '0;
        end else if (w_tail_branch) begin
            w_issue_cnt = w_avail - IW'(1);
        end else begin
            w_issue_cnt = w_avail;
        end
    end

    assign bus.issue_count = w_issue_cnt;
    assign w_pop_cnt       = bus.issue_ready ? w_issue_cnt : '0;

    // Queue pointers and occupancy; flush empties the queue on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_pop_cnt);
            r_tail  <= r_tail + PW'(w_push_cnt);
            r_count <= r_count + NW'(w_push_cnt) - NW'(w_pop_cnt);
        end
    end

    // Entry storage: write the valid lanes of an accepted beat at the tail.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (CW'(i) < bus.fetch_cnt) begin
                    r_mem[r_tail + PW'(i)] <= w_dec[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_id_decode_queue;
    import cpu_defs::*;

    localparam int FW    = 2;
    localparam int IWID  = 2;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_decode_queue_if #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IWID)) bus ();

    id_decode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IWID), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        Oper_t       op;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  wa;
        logic        we;
        logic [31:0] imm;
        logic [31:0] pc;
        bit          ck_r1;
        bit          ck_r2;
    } exp_t;

    exp_t mq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int          obs_cnt;
    logic        obs_ready;
    Oper_t       obs_op  [IWID];
    logic [31:0] obs_imm [IWID];
    logic [31:0] obs_pc  [IWID];
    logic [4:0]  obs_r1  [IWID];
    logic [4:0]  obs_wa  [IWID];
    logic        obs_we  [IWID];
    logic        obs_inv [IWID];

    function automatic logic [31:0] enc(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] k);
        return {opc, rs, rt, k};
    endfunction

    function automatic bit model_is_branch(input Oper_t op);
        return op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL};
    endfunction

    // Reference decode: classify the instruction, then apply the operand rules per class.
    function automatic exp_t model_decode(input logic [31:0] inst, input logic [31:0] pc);
        exp_t        e;
        logic [5:0]  opc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] sx;
        opc = inst[31:26];
        rs  = inst[25:21];
        rt  = inst[20:16];
        sx  = {{16{inst[15]}}, inst[15:0]};
        e = '{op: OP_INVALID, r1: 5'd0, r2: 5'd0, wa: 5'd0, we: 1'b0, imm: sx, pc: pc, ck_r1: 1'b0, ck_r2: 1'b0};
        case (opc)
            6'h0C: e.op = OP_ANDI;
            6'h0D: e.op = OP_ORI;
            6'h0E: e.op = OP_XORI;
            6'h0F: e.op = OP_LUI;
            6'h09: e.op = OP_ADDIU;
            6'h0A: e.op = OP_SLTI;
            6'h0B: e.op = OP_SLTIU;
            6'h04: e.op = OP_BEQ;
            6'h05: e.op = OP_BNE;
            6'h06: e.op = OP_BLEZ;
            6'h07: e.op = OP_BGTZ;
            6'h23: e.op = OP_LW;
            6'h20: e.op = OP_LB;
            6'h24: e.op = OP_LBU;
            6'h2B: e.op = OP_SW;
            6'h28: e.op = OP_SB;
            6'h01: begin
                if (rt == 5'h00)      e.op = OP_BLTZ;
                else if (rt == 5'h01) e.op = OP_BGEZ;
                else if (rt == 5'h10) e.op = OP_BLTZAL;
                else if (rt == 5'h11) e.op = OP_BGEZAL;
                else if (rt == 5'h0C) e.op = OP_TEQI;
            end
            default: e.op = OP_INVALID;
        endcase
        if (e.op inside {OP_ANDI, OP_ORI, OP_XORI, OP_ADDIU, OP_SLTI, OP_SLTIU}) begin
            e.r1 = rs; e.ck_r1 = 1'b1; e.wa = rt; e.we = 1'b1;
            if (e.op inside {OP_ANDI, OP_ORI, OP_XORI}) e.imm = {16'h0, inst[15:0]};
        end else if (e.op == OP_LUI) begin
            e.r1 = 5'd0; e.ck_r1 = 1'b1; e.wa = rt; e.we = 1'b1; e.imm = {inst[15:0], 16'h0};
        end else if (e.op inside {OP_LW, OP_LB, OP_LBU}) begin
            e.r1 = rs; e.r2 = rt; e.ck_r1 = 1'b1; e.ck_r2 = 1'b1; e.wa = rt; e.we = 1'b1;
        end else if (e.op inside {OP_SW, OP_SB, OP_BEQ, OP_BNE}) begin
            e.r1 = rs; e.r2 = rt; e.ck_r1 = 1'b1; e.ck_r2 = 1'b1;
        end else if (e.op inside {OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ, OP_TEQI}) begin
            e.r2 = 5'd0; e.ck_r2 = 1'b1;
        end else if (e.op inside {OP_BLTZAL, OP_BGEZAL}) begin
            e.wa = 5'd31; e.we = 1'b1;
        end
        if (model_is_branch(e.op)) e.imm = sx * 4;
        return e;
    endfunction

    // One clock: compare DUT against the model at the falling edge, then
    // apply the same cycle's push/pop/flush to the model at the rising edge.
    task automatic tick();
        int   en;
        bit   er;
        exp_t e;
        @(negedge clk);
        en = (mq.size() < IWID) ? mq.size() : IWID;
        if (en > 0 && model_is_branch(mq[en-1].op)) en = en - 1;
        if (bus.flush) en = 0;
        er = (DEPTH - mq.size()) >= FW;
        obs_cnt   = int'(bus.issue_count);
        obs_ready = bus.fetch_ready;
        for (int i = 0; i < IWID; i++) begin
            obs_op[i]  = bus.issue_op[i];
            obs_imm[i] = bus.issue_imm[i];
            obs_pc[i]  = bus.issue_pc[i];
            obs_r1[i]  = bus.issue_raddr1[i];
            obs_wa[i]  = bus.issue_waddr[i];
            obs_we[i]  = bus.issue_we[i];
            obs_inv[i] = bus.issue_invalid[i];
        end
        n_cmp++;
        if (bus.issue_count !== 2'(en)) begin
            n_err++;
            $display("FAIL issue_count t=%0t got=%0d exp=%0d", $time, bus.issue_count, en);
        end
        n_cmp++;
        if (bus.fetch_ready !== logic'(er)) begin
            n_err++;
            $display("FAIL fetch_ready t=%0t got=%0b exp=%0b", $time, bus.fetch_ready, er);
        end
        for (int i = 0; i < en; i++) begin
            e = mq[i];
            n_cmp++;
            if (bus.issue_op[i] !== e.op || bus.issue_we[i] !== e.we || bus.issue_imm[i] !== e.imm ||
                bus.issue_pc[i] !== e.pc || bus.issue_invalid[i] !== (e.op == OP_INVALID) ||
                (e.ck_r1 && bus.issue_raddr1[i] !== e.r1) || (e.ck_r2 && bus.issue_raddr2[i] !== e.r2) ||
                (e.we && bus.issue_waddr[i] !== e.wa)) begin
                n_err++;
                $display("FAIL lane%0d t=%0t got op=%0d r1=%0d r2=%0d wa=%0d we=%0b imm=%h pc=%h inv=%0b exp op=%0d r1=%0d r2=%0d wa=%0d we=%0b imm=%h pc=%h",
                         i, $time, bus.issue_op[i], bus.issue_raddr1[i], bus.issue_raddr2[i], bus.issue_waddr[i],
                         bus.issue_we[i], bus.issue_imm[i], bus.issue_pc[i], bus.issue_invalid[i],
                         e.op, e.r1, e.r2, e.wa, e.we, e.imm, e.pc);
            end
        end
        $display("cycle t=%0t issue_count=%0d fetch_ready=%0b queued=%0d", $time, obs_cnt, obs_ready, mq.size());
        @(posedge clk);
        if (bus.flush) begin
            mq.delete();
        end else begin
            if (bus.issue_ready) begin
                for (int i = 0; i < en; i++) void'(mq.pop_front());
            end
            if (bus.fetch_valid && er) begin
                for (int i = 0; i < int'(bus.fetch_cnt); i++)
                    mq.push_back(model_decode(bus.fetch_inst[i], bus.fetch_pc + 32'(4 * i)));
            end
        end
        #1;
    endtask

    task automatic idle();
        bus.fetch_valid = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic beat(input int cnt, input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
        bus.fetch_valid   = 1'b1;
        bus.fetch_cnt     = 2'(cnt);
        bus.fetch_inst[0] = i0;
        bus.fetch_inst[1] = i1;
        bus.fetch_pc      = pc;
    endtask

    task automatic drain();
        idle();
        bus.issue_ready = 1'b1;
        for (int c = 0; c < 40 && mq.size() > 0; c++) tick();
        n_cmp++;
        if (mq.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout left=%0d required=0", mq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.issue_ready = 1'b0;
        bus.fetch_cnt   = 2'd1;
        bus.fetch_inst  = '0;
        bus.fetch_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.issue_count !== 2'd0 || bus.fetch_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset got cnt=%0d ready=%0b required cnt=0 ready=1", bus.issue_count, bus.fetch_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ori();
        bus.issue_ready = 1'b0;
        beat(1, enc(6'h0D, 5'd1, 5'd2, 16'h8000), 32'h0, 32'h100);
        tick();
        idle();
        tick();
        n_cmp++;
        if (obs_cnt != 1 || obs_op[0] !== OP_ORI || obs_r1[0] !== 5'd1 || obs_wa[0] !== 5'd2 || obs_we[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ori_fields got cnt=%0d op=%0d r1=%0d wa=%0d we=%0b required 1/%0d/1/2/1",
                     obs_cnt, obs_op[0], obs_r1[0], obs_wa[0], obs_we[0], OP_ORI);
        end
        n_cmp++;
        if (obs_imm[0] !== 32'h0000_8000 || obs_pc[0] !== 32'h100) begin
            n_err++;
            $display("FAIL ori_imm_pc got imm=%h pc=%h required 00008000/00000100", obs_imm[0], obs_pc[0]);
        end
        drain();
    endtask

    task automatic test_branch_pair();
        bus.issue_ready = 1'b1;
        beat(2, enc(6'h04, 5'd1, 5'd2, 16'hFFFF), enc(6'h09, 5'd0, 5'd3, 16'hFFFF), 32'h200);
        tick();
        idle();
        tick();
        n_cmp++;
        if (obs_cnt != 2 || obs_op[0] !== OP_BEQ || obs_imm[0] !== 32'hFFFF_FFFC || obs_imm[1] !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL branch_pair got cnt=%0d op0=%0d imm0=%h imm1=%h required 2/%0d/fffffffc/ffffffff",
                     obs_cnt, obs_op[0], obs_imm[0], obs_imm[1], OP_BEQ);
        end
        drain();
    endtask

    task automatic test_delay_slot();
        bus.issue_ready = 1'b1;
        beat(2, enc(6'h09, 5'd0, 5'd4, 16'd5), enc(6'h05, 5'd1, 5'd2, 16'd3), 32'h300);
        tick();
        idle();
        tick();
        n_cmp++;
        if (obs_cnt != 1 || obs_op[0] !== OP_ADDIU) begin
            n_err++;
            $display("FAIL slot_addiu_alone got cnt=%0d op=%0d required 1/%0d", obs_cnt, obs_op[0], OP_ADDIU);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (obs_cnt != 0) begin
                n_err++;
                $display("FAIL slot_branch_hold got cnt=%0d required 0", obs_cnt);
            end
        end
        beat(2, enc(6'h0D, 5'd0, 5'd5, 16'd1), enc(6'h0C, 5'd0, 5'd6, 16'd2), 32'h308);
        tick();
        n_cmp++;
        if (obs_cnt != 0) begin
            n_err++;
            $display("FAIL slot_no_bypass got cnt=%0d required 0", obs_cnt);
        end
        idle();
        tick();
        n_cmp++;
        if (obs_cnt != 2 || obs_op[0] !== OP_BNE || obs_op[1] !== OP_ORI) begin
            n_err++;
            $display("FAIL slot_group got cnt=%0d op0=%0d op1=%0d required 2/%0d/%0d",
                     obs_cnt, obs_op[0], obs_op[1], OP_BNE, OP_ORI);
        end
        drain();
    endtask

    task automatic test_full();
        bus.issue_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            beat(2, enc(6'h0D, 5'(b), 5'(b + 1), 16'(b)), enc(6'h0E, 5'(b + 2), 5'(b + 3), 16'(b + 100)), 32'h400 + 32'(8 * b));
            tick();
        end
        n_cmp++;
        if (obs_ready !== 1'b0 || obs_cnt != 2) begin
            n_err++;
            $display("FAIL full_ready got ready=%0b cnt=%0d required 0/2", obs_ready, obs_cnt);
        end
        drain();
        tick();
        n_cmp++;
        if (obs_ready !== 1'b1 || obs_cnt != 0) begin
            n_err++;
            $display("FAIL full_after_drain got ready=%0b cnt=%0d required 1/0", obs_ready, obs_cnt);
        end
    endtask

    task automatic test_flush();
        bus.issue_ready = 1'b0;
        beat(2, enc(6'h09, 5'd1, 5'd1, 16'd1), enc(6'h09, 5'd2, 5'd2, 16'd2), 32'h600);
        tick();
        beat(2, enc(6'h09, 5'd3, 5'd3, 16'd3), enc(6'h09, 5'd4, 5'd4, 16'd4), 32'h608);
        tick();
        beat(1, enc(6'h09, 5'd5, 5'd5, 16'd5), 32'h0, 32'h610);
        tick();
        beat(2, enc(6'h0D, 5'd6, 5'd6, 16'd6), enc(6'h0D, 5'd7, 5'd7, 16'd7), 32'h614);
        bus.flush       = 1'b1;
        bus.issue_ready = 1'b1;
        tick();
        n_cmp++;
        if (obs_cnt != 0) begin
            n_err++;
            $display("FAIL flush_same_cycle got cnt=%0d required 0", obs_cnt);
        end
        idle();
        tick();
        n_cmp++;
        if (obs_cnt != 0 || obs_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_next got cnt=%0d ready=%0b required 0/1", obs_cnt, obs_ready);
        end
    endtask

    task automatic test_invalid();
        bus.issue_ready = 1'b1;
        beat(2, enc(6'h3F, 5'd9, 5'd10, 16'h1234), enc(6'h0D, 5'd1, 5'd8, 16'h00FF), 32'h700);
        tick();
        idle();
        tick();
        n_cmp++;
        if (obs_cnt != 2 || obs_inv[0] !== 1'b1 || obs_op[0] !== OP_INVALID || obs_we[0] !== 1'b0 ||
            obs_inv[1] !== 1'b0 || obs_op[1] !== OP_ORI) begin
            n_err++;
            $display("FAIL invalid got cnt=%0d inv0=%0b op0=%0d we0=%0b inv1=%0b op1=%0d required 2/1/0/0/0/%0d",
                     obs_cnt, obs_inv[0], obs_op[0], obs_we[0], obs_inv[1], obs_op[1], OP_ORI);
        end
        drain();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [19:0][5:0] otab;
        logic [5:0][4:0]  rtab;
        logic [5:0]       opc;
        logic [4:0]       rt;
        otab = {6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                6'h0E, 6'h0F, 6'h20, 6'h23, 6'h24, 6'h28, 6'h2B, 6'h3F, 6'h01, 6'h11};
        rtab = {5'h00, 5'h01, 5'h10, 5'h11, 5'h0C, 5'h05};
        opc  = otab[$urandom_range(0, 19)];
        rt   = (opc == 6'h01) ? rtab[$urandom_range(0, 5)] : 5'($urandom);
        return {opc, 5'($urandom), rt, 16'($urandom)};
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.fetch_valid   = ($urandom_range(0, 3) != 0);
            bus.fetch_cnt     = 2'($urandom_range(1, 2));
            bus.fetch_inst[0] = rand_inst();
            bus.fetch_inst[1] = rand_inst();
            bus.fetch_pc      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            bus.issue_ready   = ($urandom_range(0, 2) != 0);
            bus.flush         = ($urandom_range(0, 39) == 0);
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bus.issue_ready = 1'b0;
        beat(2, enc(6'h0D, 5'd1, 5'd2, 16'd3), enc(6'h0D, 5'd3, 5'd4, 16'd5), 32'h800);
        tick();
        tick();
        idle();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.issue_count !== 2'd0 || bus.fetch_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_async got cnt=%0d ready=%0b required 0/1", bus.issue_count, bus.fetch_ready);
        end
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ori();
        test_branch_pair();
        test_delay_slot();
        test_full();
        test_flush();
        test_invalid();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_decode_queue.md
# id_decode_queue

Multi-lane decode-and-buffer stage that sits between instruction fetch and issue in the CPU pipeline. It accepts up to FETCH_WIDTH instructions per cycle and decodes each I-type instruction at enqueue into operation, register addresses, write enable and an extended immediate. Decoded entries are held in an in-order circular queue of DEPTH entries and presented to issue up to ISSUE_WIDTH per cycle. Issue groups never separate a branch from its delay slot.

## Interface
Parameters:
- FETCH_WIDTH, 2, instructions accepted per fetch beat (≥1)
- ISSUE_WIDTH, 2, max entries presented per cycle (≥2)
- DEPTH, 8, queue entries; power of two, ≥ FETCH_WIDTH+ISSUE_WIDTH

Ports (CW = $clog2(FETCH_WIDTH+1), IW = $clog2(ISSUE_WIDTH+1)):
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  discard all queued entries
- fetch_valid  in  1  fetch beat present
- fetch_ready  out  1  queue can take a full beat
- fetch_cnt  in  CW  valid lanes in beat, 1..FETCH_WIDTH, lanes 0..cnt-1
- fetch_inst  in  FETCH_WIDTH×Inst_t  instructions
- fetch_pc  in  32  PC of lane 0; lane i PC = fetch_pc + 4i
- issue_count  out  IW  entries presented, lanes 0..count-1
- issue_ready  in  1  consumer takes all presented entries
- issue_op  out  ISSUE_WIDTH×Oper_t  decoded operation
- issue_raddr1, issue_raddr2, issue_waddr  out  ISSUE_WIDTH×RegAddr_t  register addresses
- issue_we  out  ISSUE_WIDTH×1  register write enable
- issue_imm  out  ISSUE_WIDTH×32  extended immediate
- issue_pc  out  ISSUE_WIDTH×32  instruction PC
- issue_invalid  out  ISSUE_WIDTH×1  op is OP_INVALID (reserved instruction)

## Operation
- Decode per lane at enqueue; stored entries are fully decoded.
- Lane decode covers ANDI, ORI, XORI, LUI, ADDIU, SLTI, SLTIU, BEQ, BNE, BLEZ, BGTZ, REGIMM (BLTZ, BGEZ, BLTZAL, BGEZAL, TEQI), LW, LB, LBU, SW, SB. Anything else decodes to OP_INVALID with we=0.
- Register rules:
  - ALU-immediate: raddr1=rs, waddr=rt, we=1.
  - LUI: raddr1=0.
  - Loads: raddr1=rs, raddr2=rt, waddr=rt, we=1.
  - Stores: raddr1=rs, raddr2=rt, we=0.
  - BEQ/BNE: raddr1=rs, raddr2=rt, we=0.
  - BLEZ/BGTZ/BLTZ/BGEZ/TEQI: raddr2=0, we=0.
  - BLTZAL/BGEZAL: waddr=31, we=1.
- Immediate rules:
  - ANDI/ORI/XORI: zero-extend.
  - LUI: {imm,16'b0}.
  - Branches: sign-extend(imm)<<2.
  - All others: sign-extend.
- Enqueue:
  - fetch_ready = (DEPTH − count) ≥ FETCH_WIDTH, from registered count only.
  - Push when fetch_valid && fetch_ready; writes fetch_cnt entries at the tail.
- Issue:
  - n = min(count, ISSUE_WIDTH).
  - If lane n−1 is a branch (any BEQ..BGEZAL op), issue_count = n−1; otherwise issue_count = n. The branch waits for its delay slot.
  - Pop issue_count entries when issue_ready && !flush.
  - Outputs for lanes ≥ issue_count are don't-care.
- flush:
  - Forces issue_count=0 combinationally.
  - Any push in the same cycle is dropped.
  - Next edge: head=tail=count=0.

## Timing
- Reset (async assert): head=tail=count=0; issue_count=0; fetch_ready=1.
- Enqueue-to-issue latency: 1 cycle. An entry pushed at edge N is visible from cycle N+1.
- No bypass from fetch to issue.
- Simultaneous push and pop in one cycle are both applied: count' = count + push_cnt − pop_cnt.
- Pointers wrap modulo DEPTH. Full (count=DEPTH) and empty (count=0) are distinguished by count.
- Empty: issue_count=0. A single queued branch gives issue_count=0 until its slot arrives.
- rst mid-operation discards all entries immediately.

## Structure
- Shared cpu_defs package holds Oper_t additions (OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LB, OP_LBU, OP_SB) and an is_branch(Oper_t) function.
- Also in cpu_defs: a DecodedInst_t struct (op, raddr1, raddr2, waddr, we, imm, pc).
- One sub-module: id_decode_lane, a combinational single-instruction decoder instantiated FETCH_WIDTH times.

## Test plan
- Reset, then push ORI r2,r1,0x8000 at pc 0x100 → next cycle issue_count=1, op=OP_ORI, raddr1=1, waddr=2, we=1, imm=0x00008000, pc=0x100.
- Push {BEQ r1,r2,-1; ADDIU r3,r0,-1}, issue_ready=1 → both issue in one group; imm0=0xFFFFFFFC, imm1=0xFFFFFFFF.
- Push {ADDIU, BNE} then 3 idle cycles → ADDIU alone issues; BNE holds with issue_count=0 until the next beat supplies its slot, then BNE+slot issue together.
- Hold issue_ready=0 and push 4 beats with DEPTH=8 → fetch_ready=0 after count=8; no overwrite. Release → in-order drain and pointer wrap verified.
- Assert flush while pushing and count=5 → issue_count=0 that cycle, the push is dropped, count=0 next cycle.
- Push opcode 6'b111111 → issue_invalid=1, op=OP_INVALID, we=0; queue continues normally.
